// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// The TDM_DEMUX_ERR_CNT_EN option, used by tdm_demux, relies on ERR_CNT_W.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int unsigned ERR_CNT_W = 8;

    // Slot index width; a degenerate channel count still gets one bit.
    function automatic int unsigned slot_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame slot counter: increment with wrap, load-to-1 on frame start, and clear.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SW       = slot_width(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] slot,
    output logic          wrap_c
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    assign wrap_c = inc && (slot == LAST_SLOT);

    // clear and load take priority over increment; callers never assert more than one
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= wrap_c ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers interleaved words into held per-channel registers.
// Optional TDM_DEMUX_ERR_CNT_EN adds a saturating sync-error counter output err_cnt.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      sync_err,
`ifdef TDM_DEMUX_ERR_CNT_EN
    output logic                      locked,
    output logic [ERR_CNT_W-1:0]      err_cnt
`else
    output logic                      locked
`endif
);

    localparam int unsigned SW = slot_width(CHANNELS);

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot;
    logic                      wrap_c;
    logic                      inc, load1, clr;
    logic                      wr_en;
    logic [SW-1:0]             wr_idx;
    logic [CHANNELS*WIDTH-1:0] ch_data_d;
    logic [CHANNELS-1:0]       ch_valid_d;
    logic                      frame_done_d;
    logic                      sync_err_d;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .SW       (SW)
    ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .load1  (load1),
        .clr    (clr),
        .slot   (slot),
        .wrap_c (wrap_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Alignment decisions; a sync word always restarts the frame at slot 0
    always_comb begin
        state_d      = state_q;
        inc          = 1'b0;
        load1        = 1'b0;
        clr          = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        ch_data_d    = ch_data;
        ch_valid_d   = '0;

        case (state_q)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    wr_en   = 1'b1;
                    load1   = 1'b1;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (din_valid) begin
                    if (slot == '0) begin
                        if (frame_sync) begin
                            wr_en = 1'b1;
                            load1 = 1'b1;
                        end else begin
                            sync_err_d = 1'b1;
                            clr        = 1'b1;
                            state_d    = HUNT;
                        end
                    end else if (frame_sync) begin
                        sync_err_d = 1'b1;
                        wr_en      = 1'b1;
                        load1      = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        wr_idx       = slot;
                        inc          = 1'b1;
                        frame_done_d = wrap_c;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (wr_en) begin
            ch_data_d[32'(wr_idx)*WIDTH +: WIDTH] = din;
            ch_valid_d[wr_idx]                    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            ch_data    <= ch_data_d;
            ch_valid   <= ch_valid_d;
            frame_done <= frame_done_d;
            sync_err   <= sync_err_d;
        end
    end

    assign locked = (state_q == LOCK);

`ifdef TDM_DEMUX_ERR_CNT_EN
    // Counts alongside the sync_err pulse register; holds at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (sync_err_d && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus randomized traffic
// compared against a word-level reference model.
module tb_tdm_demux;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [WIDTH-1:0]          din;
    logic                      din_valid;
    logic                      frame_sync;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]       ch_valid;
    logic                      frame_done;
    logic                      sync_err;
    logic                      locked;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]                err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
`ifdef TDM_DEMUX_ERR_CNT_EN
        .locked     (locked),
        .err_cnt    (err_cnt)
`else
        .locked     (locked)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: channel words as an array, frame position as a plain integer
    logic [WIDTH-1:0]    m_ch [CHANNELS];
    logic                m_locked;
    int                  m_slot;
    int                  m_errcnt;
    logic [CHANNELS-1:0] m_valid;
    logic                m_done;
    logic                m_err;

    function automatic logic [CHANNELS*WIDTH-1:0] m_data();
        logic [CHANNELS*WIDTH-1:0] r;
        for (int k = 0; k < int'(CHANNELS); k++) r[k*WIDTH +: WIDTH] = m_ch[k];
        return r;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] d);
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            for (int k = 0; k < int'(CHANNELS); k++) m_ch[k] = '0;
            m_locked = 1'b0;
            m_slot   = 0;
            m_errcnt = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0] = d; m_valid = 1; m_slot = 1; m_locked = 1'b1;
                end
            end else if (s) begin
                m_err   = (m_slot != 0);
                m_ch[0] = d; m_valid = 1; m_slot = 1;
            end else if (m_slot == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_ch[m_slot] = d;
                m_valid      = CHANNELS'(1) << m_slot;
                m_done       = (m_slot == int'(CHANNELS) - 1);
                m_slot       = (m_slot + 1) % int'(CHANNELS);
            end
            if (m_err && m_errcnt < 255) m_errcnt++;
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic cycle(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] d);
        rst = r; din_valid = v; frame_sync = s; din = d;
        @(posedge clk);
        #1;
        model_step(r, v, s, d);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 4'hF);
            n_checks++;
            if ({ch_data, ch_valid, frame_done, sync_err, locked} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: data=%h valid=%b done=%b err=%b locked=%b, required all 0",
                         ch_data, ch_valid, frame_done, sync_err, locked);
            end
`ifdef TDM_DEMUX_ERR_CNT_EN
            n_checks++;
            if (err_cnt !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_err_cnt: got %h, required 00", err_cnt);
            end
`endif
        end
    endtask

    task automatic test_frame();
        logic [WIDTH-1:0]    words [4] = '{4'h5, 4'hA, 4'hF, 4'hE};
        logic [CHANNELS-1:0] vexp  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, (i == 0), words[i]);
            n_checks++;
            if (ch_valid !== vexp[i] || frame_done !== (i == 3) || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_word%0d: valid=%b done=%b locked=%b, required valid=%b done=%b locked=1",
                         i, ch_valid, frame_done, locked, vexp[i], (i == 3));
            end
        end
        n_checks++;
        if (ch_data !== 16'hEFA5) begin
            n_fail++;
            $display("FAIL frame_data: got %h, required EFA5", ch_data);
        end
        cycle(1'b0, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if (ch_valid !== '0 || frame_done !== 1'b0 || ch_data !== 16'hEFA5) begin
            n_fail++;
            $display("FAIL frame_idle_hold: valid=%b done=%b data=%h, required 0 0 EFA5",
                     ch_valid, frame_done, ch_data);
        end
    endtask

    task automatic test_hunt();
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h3);
        n_checks++;
        if (ch_valid !== '0 || locked !== 1'b0 || ch_data !== '0) begin
            n_fail++;
            $display("FAIL hunt_drop: valid=%b locked=%b data=%h, required 0 0 0", ch_valid, locked, ch_data);
        end
        cycle(1'b0, 1'b1, 1'b1, 4'h7);
        n_checks++;
        if (ch_valid !== 4'b0001 || ch_data[3:0] !== 4'h7 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL hunt_sync: valid=%b ch0=%h locked=%b, required 0001 7 1", ch_valid, ch_data[3:0], locked);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'hB);
        n_checks++;
        if (ch_valid !== '0 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hunt_gap: valid=%b err=%b, required 0 0", ch_valid, sync_err);
        end
        cycle(1'b0, 1'b1, 1'b0, 4'h9);
        n_checks++;
        if (ch_valid !== 4'b0010 || ch_data[7:4] !== 4'h9 || ch_data[3:0] !== 4'h7) begin
            n_fail++;
            $display("FAIL hunt_ch1: valid=%b data=%h, required 0010 xx97", ch_valid, ch_data);
        end
    endtask

    task automatic test_early_sync();
        cycle(1'b0, 1'b1, 1'b1, 4'hC);
        n_checks++;
        if (sync_err !== 1'b1 || ch_valid !== 4'b0001 || ch_data[3:0] !== 4'hC ||
            locked !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync: err=%b valid=%b ch0=%h locked=%b done=%b, required 1 0001 C 1 0",
                     sync_err, ch_valid, ch_data[3:0], locked, frame_done);
        end
        cycle(1'b0, 1'b1, 1'b0, 4'h1);
        n_checks++;
        if (ch_valid !== 4'b0010 || ch_data[7:4] !== 4'h1 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_next: valid=%b ch1=%h done=%b err=%b, required 0010 1 0 0",
                     ch_valid, ch_data[7:4], frame_done, sync_err);
        end
    endtask

    task automatic test_missing_sync();
        logic [CHANNELS*WIDTH-1:0] held;
        cycle(1'b0, 1'b1, 1'b0, 4'h2);
        cycle(1'b0, 1'b1, 1'b0, 4'h3);
        n_checks++;
        if (frame_done !== 1'b1 || ch_valid !== 4'b1000) begin
            n_fail++;
            $display("FAIL missing_prefill: done=%b valid=%b, required 1 1000", frame_done, ch_valid);
        end
        held = ch_data;
        cycle(1'b0, 1'b1, 1'b0, 4'h6);
        n_checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== '0 ||
            ch_data !== held || ch_data !== m_data()) begin
            n_fail++;
            $display("FAIL missing_sync: err=%b locked=%b valid=%b data=%h, required 1 0 0 %h",
                     sync_err, locked, ch_valid, ch_data, m_data());
        end
`ifdef TDM_DEMUX_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 8'(m_errcnt)) begin
            n_fail++;
            $display("FAIL err_cnt_count: got %0d, required %0d", err_cnt, m_errcnt);
        end
        cycle(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1, 4'(i));
        n_checks++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_cnt_saturate: got %h, required FF", err_cnt);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        cycle(1'b0, 1'b1, 1'b1, 4'h8);
        cycle(1'b0, 1'b1, 1'b0, 4'hD);
        cycle(1'b1, 1'b1, 1'b1, 4'h5);
        n_checks++;
        if (ch_data !== '0 || locked !== 1'b0 || ch_valid !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: data=%h locked=%b valid=%b, required 0 0 0", ch_data, locked, ch_valid);
        end
        cycle(1'b0, 1'b1, 1'b0, 4'h4);
        n_checks++;
        if (ch_data !== '0 || ch_valid !== '0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_nosync: data=%h valid=%b locked=%b, required 0 0 0", ch_data, ch_valid, locked);
        end
    endtask

    task automatic test_random();
        logic r, v, s;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (m_locked && m_slot != 0) s = ($urandom_range(0, 15) == 0);
            else                         s = ($urandom_range(0, 15) != 0);
            cycle(r, v, s, 4'($urandom));
            n_checks++;
            if (ch_data !== m_data() || ch_valid !== m_valid || frame_done !== m_done ||
                sync_err !== m_err || locked !== m_locked) begin
                n_fail++;
                $display("FAIL random_cycle%0d: data=%h valid=%b done=%b err=%b locked=%b, required %h %b %b %b %b",
                         i, ch_data, ch_valid, frame_done, sync_err, locked,
                         m_data(), m_valid, m_done, m_err, m_locked);
            end
`ifdef TDM_DEMUX_ERR_CNT_EN
            n_checks++;
            if (err_cnt !== 8'(m_errcnt)) begin
                n_fail++;
                $display("FAIL random_err_cnt%0d: got %0d, required %0d", i, err_cnt, m_errcnt);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
        model_step(1'b1, 1'b0, 1'b0, '0);
        test_reset();
        test_frame();
        test_hunt();
        test_early_sync();
        test_missing_sync();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
